// File: rtl/redundancy_scheduler_pkg.sv
// Shared definitions for the redundancy scheduler: default parameters and FSM state encoding.
// Users of the redundancy controller import this to stay aligned with the scheduler.
package redundancy_scheduler_pkg;

    localparam int DEF_WORD_WIDTH    = 8;
    localparam int DEF_RSIZ_WIDTH    = 2;
    localparam int DEF_MAX_LIFM_RSIZ = 3;
    localparam int DEF_TIMEOUT       = 255;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/redundancy_scheduler_wait_timer.sv
// Down-counting watchdog for the WAIT state: clear reloads, enable counts, expired at zero.
// Reloaded with TIMEOUT-1 so that expired is seen on the TIMEOUT-th enabled cycle.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= CW'(TIMEOUT - 1);
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/redundancy_scheduler.sv
// Schedules LIFM row reads in partitions of up to rsiz rows, hands each partition to the
// redundancy controller and forwards its result to the consumer, with a WAIT watchdog.
//
// state | meaning
// IDLE  | waiting for start
// FEED  | issuing p row reads for the current partition
// DRAIN | last read data / kidx presented to the controller
// WAIT  | waiting for controller result and consumer acceptance
// DONE  | one-cycle done pulse
module redundancy_scheduler
    import redundancy_scheduler_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int RSIZ_WIDTH    = DEF_RSIZ_WIDTH,
    parameter int MAX_LIFM_RSIZ = DEF_MAX_LIFM_RSIZ,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] cfg_nrows,
    input  logic [RSIZ_WIDTH-1:0] cfg_rsiz,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    output logic                  rd_en,
    output logic [WORD_WIDTH-1:0] rd_addr,
    output logic                  rc_enable,
    output logic [RSIZ_WIDTH-1:0] rc_rsiz,
    output logic [WORD_WIDTH-1:0] rc_kidx,
    output logic                  rc_col_valid,
    input  logic                  rc_valid,
    output logic                  cons_valid,
    input  logic                  cons_ready,
    output logic [WORD_WIDTH-1:0] part_cnt
);

    localparam logic [RSIZ_WIDTH-1:0] MAX_RSIZ = RSIZ_WIDTH'(MAX_LIFM_RSIZ);

    function automatic logic [RSIZ_WIDTH-1:0] clamp_rsiz(input logic [RSIZ_WIDTH-1:0] r);
        if (r == '0)            return RSIZ_WIDTH'(1);
        else if (r > MAX_RSIZ)  return MAX_RSIZ;
        else                    return r;
    endfunction

    function automatic logic [RSIZ_WIDTH-1:0] part_size(input logic [RSIZ_WIDTH-1:0] r,
                                                        input logic [WORD_WIDTH-1:0] remaining);
        if (remaining < WORD_WIDTH'(r)) return RSIZ_WIDTH'(remaining);
        else                            return r;
    endfunction

    sched_state_t          state;
    logic [WORD_WIDTH-1:0] nrows_q;
    logic [RSIZ_WIDTH-1:0] rsiz_q;
    logic [WORD_WIDTH-1:0] base;
    logic [RSIZ_WIDTH-1:0] idx;

    logic [RSIZ_WIDTH-1:0] rsiz_start;
    logic [WORD_WIDTH-1:0] base_next;
    logic                  handshake;
    logic                  last_feed;
    logic                  timer_clear;
    logic                  timer_en;
    logic                  timer_expired;

    assign rsiz_start  = clamp_rsiz(cfg_rsiz);
    assign base_next   = base + WORD_WIDTH'(rc_rsiz);
    assign handshake   = (state == ST_WAIT) && rc_valid && cons_ready;
    assign last_feed   = (idx == (rc_rsiz - 1'b1));
    assign timer_clear = (state == ST_DRAIN) || ((state == ST_WAIT) && rc_valid);
    assign timer_en    = (state == ST_WAIT) && !rc_valid;

    // Gated by the registered state so the consumer handshake happens in the same cycle as rc_valid.
    assign cons_valid  = (state == ST_WAIT) && rc_valid;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .expired (timer_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            nrows_q      <= '0;
            rsiz_q       <= '0;
            base         <= '0;
            idx          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err_timeout  <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            rc_enable    <= 1'b0;
            rc_rsiz      <= '0;
            rc_kidx      <= '0;
            rc_col_valid <= 1'b0;
            part_cnt     <= '0;
        end else begin
            // Read data returns one cycle after rd_en, so kidx follows the address by one cycle.
            rc_col_valid <= rd_en;
            if (rd_en) rc_kidx <= rd_addr;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        nrows_q     <= cfg_nrows;
                        rsiz_q      <= rsiz_start;
                        err_timeout <= 1'b0;
                        part_cnt    <= '0;
                        base        <= '0;
                        busy        <= 1'b1;
                        if (cfg_nrows == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_FEED;
                            rd_en     <= 1'b1;
                            rd_addr   <= '0;
                            rc_enable <= 1'b1;
                            rc_rsiz   <= part_size(rsiz_start, cfg_nrows);
                            idx       <= '0;
                        end
                    end
                end
                ST_FEED: begin
                    rc_enable <= 1'b0;
                    if (last_feed) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        idx     <= idx + 1'b1;
                        rd_addr <= rd_addr + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (handshake) begin
                        base     <= base_next;
                        part_cnt <= part_cnt + 1'b1;
                        if (base_next == nrows_q) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= ST_FEED;
                            rd_en     <= 1'b1;
                            rd_addr   <= base_next;
                            rc_enable <= 1'b1;
                            rc_rsiz   <= part_size(rsiz_q, nrows_q - base_next);
                            idx       <= '0;
                        end
                    end else if (!rc_valid && timer_expired) begin
                        state       <= ST_IDLE;
                        busy        <= 1'b0;
                        err_timeout <= 1'b1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_redundancy_scheduler.sv
// Randomized scoreboard bench for redundancy_scheduler: a job-level model fills expectation
// queues, a monitor pops and compares, and a responder plays controller and consumer.
module tb_redundancy_scheduler;

    localparam int WW   = 8;
    localparam int RW   = 3;
    localparam int MAXR = 3;
    localparam int TO   = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] cfg_nrows = '0;
    logic [RW-1:0] cfg_rsiz = '0;
    logic          busy, done, err_timeout, rd_en, rc_enable, rc_col_valid, cons_valid;
    logic [WW-1:0] rd_addr, rc_kidx, part_cnt;
    logic [RW-1:0] rc_rsiz;
    logic          rc_valid = 1'b0;
    logic          cons_ready = 1'b0;

    redundancy_scheduler #(
        .WORD_WIDTH(WW), .RSIZ_WIDTH(RW), .MAX_LIFM_RSIZ(MAXR), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .cfg_nrows(cfg_nrows), .cfg_rsiz(cfg_rsiz),
        .busy(busy), .done(done), .err_timeout(err_timeout), .rd_en(rd_en), .rd_addr(rd_addr),
        .rc_enable(rc_enable), .rc_rsiz(rc_rsiz), .rc_kidx(rc_kidx), .rc_col_valid(rc_col_valid),
        .rc_valid(rc_valid), .cons_valid(cons_valid), .cons_ready(cons_ready), .part_cnt(part_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int p;
        int base;
        int idx;
    } part_t;

    part_t exp_part[$];
    int    exp_addr[$];
    int    exp_kidx[$];
    int    exp_done[$];

    int n_checks = 0;
    int n_pass   = 0;

    bit mon_on      = 1'b0;
    bit resp_enable = 1'b1;
    int resp_delay  = 0;
    int resp_stall  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Job-level reference: split nrows into partitions of the clamped size.
    task automatic model_job(input int nrows, input int rsiz, input bit with_done);
        int r;
        int b;
        int k;
        int p;
        r = (rsiz == 0) ? 1 : ((rsiz > MAXR) ? MAXR : rsiz);
        b = 0;
        k = 0;
        while (b < nrows) begin
            p = ((nrows - b) < r) ? (nrows - b) : r;
            exp_part.push_back('{p: p, base: b, idx: k});
            for (int i = 0; i < p; i++) begin
                exp_addr.push_back(b + i);
                exp_kidx.push_back(b + i);
            end
            b += p;
            k++;
        end
        if (with_done) exp_done.push_back(k);
    endtask

    task automatic flush_queues();
        exp_part.delete();
        exp_addr.delete();
        exp_kidx.delete();
        exp_done.delete();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err_timeout, 0);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_rc_enable"}, rc_enable, 0);
        chk({tag, "_rc_rsiz"}, int'(rc_rsiz), 0);
        chk({tag, "_rc_kidx"}, int'(rc_kidx), 0);
        chk({tag, "_col_valid"}, rc_col_valid, 0);
        chk({tag, "_cons_valid"}, cons_valid, 0);
        chk({tag, "_part_cnt"}, int'(part_cnt), 0);
    endtask

    // Monitor: compares every DUT event against the head of the matching queue.
    initial begin
        int    cur_p;
        bit    prev_rd;
        bit    prev_done;
        part_t pe;
        cur_p     = 0;
        prev_rd   = 1'b0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_on && reset_n) begin
                chk("col_valid_lag", rc_col_valid, prev_rd);
                chk("cons_valid", cons_valid, rc_valid);
                if (rc_enable) begin
                    if (exp_part.size() == 0) begin
                        chk("unexpected_rc_enable", rc_enable, 0);
                    end else begin
                        pe = exp_part.pop_front();
                        cur_p = pe.p;
                        chk("rc_rsiz", int'(rc_rsiz), pe.p);
                        chk("part_base", int'(rd_addr), pe.base);
                        chk("part_cnt_at_start", int'(part_cnt), pe.idx);
                        chk("rd_en_with_enable", rd_en, 1);
                    end
                end
                if (rd_en) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_rd_en", rd_en, 0);
                    end else begin
                        chk("rd_addr", int'(rd_addr), exp_addr.pop_front());
                        chk("rc_rsiz_hold", int'(rc_rsiz), cur_p);
                    end
                end
                if (rc_col_valid) begin
                    if (exp_kidx.size() == 0) chk("unexpected_col_valid", rc_col_valid, 0);
                    else chk("rc_kidx", int'(rc_kidx), exp_kidx.pop_front());
                end
                if (done) begin
                    chk("done_single", prev_done, 0);
                    chk("done_rd_en", rd_en, 0);
                    chk("done_rc_enable", rc_enable, 0);
                    chk("done_busy", busy, 1);
                    chk("done_err", err_timeout, 0);
                    if (exp_done.size() == 0) chk("unexpected_done", done, 0);
                    else chk("part_cnt_final", int'(part_cnt), exp_done.pop_front());
                end
            end
            prev_rd   = rd_en;
            prev_done = done;
        end
    end

    // Responder: models the controller result latency and a consumer with random backpressure.
    initial begin
        int mode;
        int cnt;
        int stall_left;
        mode = 0;
        cnt = 0;
        stall_left = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                rc_valid   = 1'b0;
                cons_ready = 1'b0;
                mode       = 0;
            end else begin
                case (mode)
                    0: begin
                        if (resp_enable && rc_col_valid && !rd_en) begin
                            cnt = (resp_delay > 0) ? resp_delay : int'($urandom_range(1, 6));
                            stall_left = resp_stall;
                            mode = 1;
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            rc_valid = 1'b1;
                            if (stall_left > 0) begin
                                cons_ready = 1'b0;
                                stall_left--;
                            end else begin
                                cons_ready = ($urandom_range(0, 3) != 0);
                            end
                            mode = 2;
                        end
                    end
                    default: begin
                        if (rc_valid && cons_ready) begin
                            rc_valid   = 1'b0;
                            cons_ready = 1'b0;
                            mode       = 0;
                        end else if (stall_left > 0) begin
                            cons_ready = 1'b0;
                            stall_left--;
                        end else begin
                            cons_ready = ($urandom_range(0, 3) != 0);
                        end
                    end
                endcase
            end
        end
    end

    task automatic run_job(input int nrows, input int rsiz);
        model_job(nrows, rsiz, 1'b1);
        @(posedge clk);
        #1;
        cfg_nrows = WW'(nrows);
        cfg_rsiz  = RW'(rsiz);
        start     = 1'b1;
        @(posedge clk);
        #1;
        chk("busy_after_start", busy, 1);
        chk("err_cleared_by_start", err_timeout, 0);
        // Keep start high and scramble cfg while the job runs; both must be ignored.
        cfg_nrows = WW'($urandom);
        cfg_rsiz  = RW'($urandom);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 3000 && exp_done.size() != 0; i++) @(negedge clk);
        chk("done_pending", exp_done.size(), 0);
        for (int i = 0; i < 50 && busy; i++) @(negedge clk);
        chk("busy_end", busy, 0);
        chk("reads_left", exp_addr.size(), 0);
        chk("kidx_left", exp_kidx.size(), 0);
        chk("parts_left", exp_part.size(), 0);
        flush_queues();
    endtask

    initial begin
        int k;
        bit found;

        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        mon_on  = 1'b1;

        resp_delay = 4;
        run_job(9, 3);
        resp_delay = 0;
        run_job(7, 3);
        run_job(2, 0);
        run_job(5, 7);
        run_job(6, 4);
        run_job(0, 2);
        run_job(1, 1);
        for (int j = 0; j < 25; j++) run_job(int'($urandom_range(0, 20)), int'($urandom_range(0, 7)));

        resp_delay = 2;
        resp_stall = 300;
        run_job(2, 2);
        resp_stall = 0;
        resp_delay = 0;

        // Controller never answers: watchdog must abort without done.
        resp_enable = 1'b0;
        model_job(3, 3, 1'b0);
        @(posedge clk);
        #1;
        cfg_nrows = 8'd3;
        cfg_rsiz  = 3'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rc_col_valid && !rd_en) begin
                found = 1'b1;
                break;
            end
        end
        chk("drain_seen", found, 1);
        k = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            k++;
            if (err_timeout) break;
        end
        chk("timeout_cycles", k, TO + 1);
        chk("timeout_err", err_timeout, 1);
        chk("timeout_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("timeout_err_sticky", err_timeout, 1);
        flush_queues();
        resp_enable = 1'b1;
        run_job(0, 1);

        // Reset in the middle of FEED abandons the job.
        mon_on = 1'b0;
        @(posedge clk);
        #1;
        cfg_nrows = 8'd9;
        cfg_rsiz  = 3'd3;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_feed", rd_en, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_done", done, 0);
        chk("post_reset_rd_en", rd_en, 0);
        flush_queues();
        mon_on = 1'b1;
        run_job(4, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
